// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-stage controller.
// Holds the FSM state encoding, the address-region classification, the
// register-tag width and the default memory map.
package mem_stage_pkg;

   localparam int TAG_W        = 5;

   localparam int DEF_ROM_BASE = 1000;
   localparam int DEF_RAM_BASE = 31000;
   localparam int DEF_MEM_END  = 61015;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REG_ROM     = 2'd0,
      REG_RAM     = 2'd1,
      REG_ILLEGAL = 2'd2
   } region_e;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: request, response and memory-controller signals of the memory
// stage. The slave modport is the controller's view, master is the view of
// the surrounding pipeline/memory model.
interface mem_stage_if
   import mem_stage_pkg::*;
#(
   parameter int S = 32,
   parameter int V = 192
) ();

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic             req_vec;
   logic [S-1:0]     req_addr;
   logic [V-1:0]     req_wd;
   logic [TAG_W-1:0] req_tag;

   logic             resp_valid;
   logic             resp_ready;
   logic [V-1:0]     resp_rd;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_fault;

   logic             mem_we;
   logic             mem_vec;
   logic [S-1:0]     mem_address;
   logic [V-1:0]     mem_wd;
   logic [V-1:0]     mem_rd;

   modport slave (
      input  req_valid, req_we, req_vec, req_addr, req_wd, req_tag,
      input  resp_ready, mem_rd,
      output req_ready, resp_valid, resp_rd, resp_tag, resp_fault,
      output mem_we, mem_vec, mem_address, mem_wd
   );

   modport master (
      output req_valid, req_we, req_vec, req_addr, req_wd, req_tag,
      output resp_ready, mem_rd,
      input  req_ready, resp_valid, resp_rd, resp_tag, resp_fault,
      input  mem_we, mem_vec, mem_address, mem_wd
   );

endinterface

// File: rtl/mem_stage_ctrl_decode.sv
// mem_region_decode: combinational address classifier. Places an address in
// ROM, RAM or the illegal region (unsigned compares over S bits) and flags a
// fault for illegal addresses and for stores into ROM.
module mem_region_decode
   import mem_stage_pkg::*;
#(
   parameter int S        = 32,
   parameter int ROM_BASE = DEF_ROM_BASE,
   parameter int RAM_BASE = DEF_RAM_BASE,
   parameter int MEM_END  = DEF_MEM_END
) (
   input  logic [S-1:0] addr_i,
   input  logic         we_i,
   output region_e      region_o,
   output logic         fault_o
);

   localparam logic [S-1:0] ROM_B = S'(ROM_BASE);
   localparam logic [S-1:0] RAM_B = S'(RAM_BASE);
   localparam logic [S-1:0] END_B = S'(MEM_END);

   // Region lookup followed by the write-protection check on ROM.
   always_comb begin
      region_o = REG_ILLEGAL;
      if (addr_i >= ROM_B && addr_i < RAM_B) begin
         region_o = REG_ROM;
      end else if (addr_i >= RAM_B && addr_i < END_B) begin
         region_o = REG_RAM;
      end
      fault_o = (region_o == REG_ILLEGAL) || (we_i && (region_o == REG_ROM));
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between execute and writeback.
// Accepts one request at a time, classifies its address, issues legal
// accesses to the memory controller, waits RD_LAT cycles for load data and
// holds the response until writeback takes it. Every output is registered.
// Optional build macro MEM_STAGE_STATS_EN adds saturating 16-bit counters of
// completed loads, stores and faults.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int S        = 32,
   parameter int V        = 192,
   parameter int ROM_BASE = DEF_ROM_BASE,
   parameter int RAM_BASE = DEF_RAM_BASE,
   parameter int MEM_END  = DEF_MEM_END,
   parameter int RD_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus,
   output logic        busy
`ifdef MEM_STAGE_STATS_EN
   ,
   output logic [15:0] stat_loads,
   output logic [15:0] stat_stores,
   output logic [15:0] stat_faults
`endif
);

   // Wait-cycle count of the final read cycle; ISSUE is wait cycle 1.
   localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

   state_e           state_q;
   logic             req_ready_q;
   logic             busy_q;
   logic             we_q;
   logic [TAG_W-1:0] tag_q;
   logic [2:0]       cnt_q;

   logic             mem_we_q;
   logic             mem_vec_q;
   logic [S-1:0]     mem_address_q;
   logic [V-1:0]     mem_wd_q;

   logic             resp_valid_q;
   logic [V-1:0]     resp_rd_q;
   logic [TAG_W-1:0] resp_tag_q;
   logic             resp_fault_q;

   region_e          dec_region;
   logic             dec_fault;
   logic             acc_fault;

   mem_region_decode #(
      .S        (S),
      .ROM_BASE (ROM_BASE),
      .RAM_BASE (RAM_BASE),
      .MEM_END  (MEM_END)
   ) u_decode (
      .addr_i   (bus.req_addr),
      .we_i     (bus.req_we),
      .region_o (dec_region),
      .fault_o  (dec_fault)
   );

   assign acc_fault = dec_fault || (dec_region == REG_ILLEGAL);

   // Control FSM with all externally visible outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         req_ready_q   <= 1'b0;
         busy_q        <= 1'b0;
         we_q          <= 1'b0;
         tag_q         <= '0;
         cnt_q         <= '0;
         mem_we_q      <= 1'b0;
         mem_vec_q     <= 1'b0;
         mem_address_q <= '0;
         mem_wd_q      <= '0;
         resp_valid_q  <= 1'b0;
         resp_rd_q     <= '0;
         resp_tag_q    <= '0;
         resp_fault_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               req_ready_q <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  we_q        <= bus.req_we;
                  tag_q       <= bus.req_tag;
                  if (acc_fault) begin
                     // Faults never reach the memory controller.
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b1;
                     resp_rd_q    <= '0;
                     resp_tag_q   <= bus.req_tag;
                  end else begin
                     state_q       <= ST_ISSUE;
                     mem_we_q      <= bus.req_we;
                     mem_vec_q     <= bus.req_vec;
                     mem_address_q <= bus.req_addr;
                     mem_wd_q      <= bus.req_wd;
                     cnt_q         <= 3'd1;
                  end
               end
            end

            ST_ISSUE, ST_WAIT: begin
               mem_we_q <= 1'b0;
               if (we_q || (cnt_q >= RD_LAT_C)) begin
                  // Stores finish after one issue cycle; loads sample data
                  // on the edge closing the last wait cycle.
                  state_q       <= ST_RESP;
                  resp_valid_q  <= 1'b1;
                  resp_fault_q  <= 1'b0;
                  resp_tag_q    <= tag_q;
                  resp_rd_q     <= we_q ? '0 : bus.mem_rd;
                  mem_vec_q     <= 1'b0;
                  mem_address_q <= '0;
                  mem_wd_q      <= '0;
                  cnt_q         <= '0;
               end else begin
                  state_q <= ST_WAIT;
                  cnt_q   <= cnt_q + 3'd1;
               end
            end

            ST_RESP: begin
               if (bus.resp_ready) begin
                  // Ready comes back one cycle after the handshake.
                  state_q      <= ST_IDLE;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  resp_valid_q <= 1'b0;
                  resp_rd_q    <= '0;
                  resp_tag_q   <= '0;
                  resp_fault_q <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_rd     = resp_rd_q;
   assign bus.resp_tag    = resp_tag_q;
   assign bus.resp_fault  = resp_fault_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_vec     = mem_vec_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_wd      = mem_wd_q;
   assign busy            = busy_q;

`ifdef MEM_STAGE_STATS_EN
   logic [15:0] stat_loads_q;
   logic [15:0] stat_stores_q;
   logic [15:0] stat_faults_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Count each completed response by kind, holding at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_loads_q  <= '0;
         stat_stores_q <= '0;
         stat_faults_q <= '0;
      end else if ((state_q == ST_RESP) && bus.resp_ready) begin
         if (resp_fault_q) begin
            stat_faults_q <= sat_inc16(stat_faults_q);
         end else if (we_q) begin
            stat_stores_q <= sat_inc16(stat_stores_q);
         end else begin
            stat_loads_q  <= sat_inc16(stat_loads_q);
         end
      end
   end

   assign stat_loads  = stat_loads_q;
   assign stat_stores = stat_stores_q;
   assign stat_faults = stat_faults_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl. Two instances share
// clock and reset: one with RD_LAT=1, one with RD_LAT=3; sel steers stimulus
// to one of them and picks which one is observed. Define MEM_STAGE_STATS_EN
// to also exercise the statistics counters.
module tb_mem_stage_ctrl;
   import mem_stage_pkg::*;

   localparam int S = 32;
   localparam int V = 192;

   logic         clk;
   logic         rst;
   logic         sel;
   logic         req_valid;
   logic         req_we;
   logic         req_vec;
   logic [S-1:0] req_addr;
   logic [V-1:0] req_wd;
   logic [4:0]   req_tag;
   logic         resp_ready;
   logic [V-1:0] mem_rd_v;
   logic         busy1, busy3;

   mem_stage_if #(.S(S), .V(V)) b1 ();
   mem_stage_if #(.S(S), .V(V)) b3 ();

   assign b1.req_valid  = req_valid & ~sel;
   assign b3.req_valid  = req_valid & sel;
   assign b1.resp_ready = resp_ready & ~sel;
   assign b3.resp_ready = resp_ready & sel;
   assign b1.req_we     = req_we;
   assign b3.req_we     = req_we;
   assign b1.req_vec    = req_vec;
   assign b3.req_vec    = req_vec;
   assign b1.req_addr   = req_addr;
   assign b3.req_addr   = req_addr;
   assign b1.req_wd     = req_wd;
   assign b3.req_wd     = req_wd;
   assign b1.req_tag    = req_tag;
   assign b3.req_tag    = req_tag;
   assign b1.mem_rd     = mem_rd_v;
   assign b3.mem_rd     = mem_rd_v;

   logic         o_req_ready, o_resp_valid, o_resp_fault, o_mem_we, o_mem_vec, o_busy;
   logic [V-1:0] o_resp_rd, o_mem_wd;
   logic [4:0]   o_resp_tag;
   logic [S-1:0] o_mem_address;

   assign o_req_ready   = sel ? b3.req_ready   : b1.req_ready;
   assign o_resp_valid  = sel ? b3.resp_valid  : b1.resp_valid;
   assign o_resp_fault  = sel ? b3.resp_fault  : b1.resp_fault;
   assign o_resp_rd     = sel ? b3.resp_rd     : b1.resp_rd;
   assign o_resp_tag    = sel ? b3.resp_tag    : b1.resp_tag;
   assign o_mem_we      = sel ? b3.mem_we      : b1.mem_we;
   assign o_mem_vec     = sel ? b3.mem_vec     : b1.mem_vec;
   assign o_mem_address = sel ? b3.mem_address : b1.mem_address;
   assign o_mem_wd      = sel ? b3.mem_wd      : b1.mem_wd;
   assign o_busy        = sel ? busy3          : busy1;

`ifdef MEM_STAGE_STATS_EN
   logic [15:0] sl1, ss1, sf1, sl3, ss3, sf3;
`endif

   mem_stage_ctrl #(.S(S), .V(V), .RD_LAT(1)) u_dut1 (
      .clk  (clk),
      .rst  (rst),
      .bus  (b1),
      .busy (busy1)
`ifdef MEM_STAGE_STATS_EN
      ,
      .stat_loads  (sl1),
      .stat_stores (ss1),
      .stat_faults (sf1)
`endif
   );

   mem_stage_ctrl #(.S(S), .V(V), .RD_LAT(3)) u_dut3 (
      .clk  (clk),
      .rst  (rst),
      .bus  (b3),
      .busy (busy3)
`ifdef MEM_STAGE_STATS_EN
      ,
      .stat_loads  (sl3),
      .stat_stores (ss3),
      .stat_faults (sf3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [V-1:0] rd;
      logic [4:0]   tag;
      logic         fault;
      int           lat;
      int           we_n;
   } exp_t;

   exp_t sb_q[$];

   // Memory-side monitor state, written only by the monitor process.
   int           we_cnt   = 0;
   int           addr_err = 0;
   logic [S-1:0] we_addr  = '0;
   logic [V-1:0] we_wd    = '0;
   logic         we_vec   = 1'b0;
   logic [S-1:0] cur_addr = '0;

   // Record store pulses and check the address is held while an access is in flight.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_mem_we) begin
            we_cnt++;
            we_addr = o_mem_address;
            we_wd   = o_mem_wd;
            we_vec  = o_mem_vec;
         end
         if (o_busy && !o_resp_valid && (o_mem_address !== cur_addr)) addr_err++;
      end
   end

   task automatic chk(input string tag, input logic [V-1:0] got, input logic [V-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_req_ready"},  o_req_ready,   '0);
      chk({pfx, "_busy"},       o_busy,        '0);
      chk({pfx, "_resp_valid"}, o_resp_valid,  '0);
      chk({pfx, "_resp_fault"}, o_resp_fault,  '0);
      chk({pfx, "_resp_rd"},    o_resp_rd,     '0);
      chk({pfx, "_resp_tag"},   o_resp_tag,    '0);
      chk({pfx, "_mem_we"},     o_mem_we,      '0);
      chk({pfx, "_mem_addr"},   o_mem_address, '0);
      chk({pfx, "_mem_wd"},     o_mem_wd,      '0);
   endtask

   task automatic do_req(input logic s3, input logic we, input logic vec,
                         input logic [S-1:0] addr, input logic [V-1:0] wd,
                         input logic [4:0] tag, input logic [V-1:0] rdv,
                         input int hold);
      exp_t e;
      logic flt;
      int   n, lat, we0, ae0;
      flt     = (addr < 32'd1000) || (addr >= 32'd61015) || (we && (addr < 32'd31000));
      e.fault = flt;
      e.tag   = tag;
      e.rd    = (flt || we) ? '0 : rdv;
      e.lat   = flt ? 1 : (we ? 2 : (s3 ? 4 : 2));
      e.we_n  = (!flt && we) ? 1 : 0;

      @(negedge clk);
      sel       = s3;
      req_valid = 1'b1;
      req_we    = we;
      req_vec   = vec;
      req_addr  = addr;
      req_wd    = wd;
      req_tag   = tag;
      mem_rd_v  = rdv;
      cur_addr  = addr;
      we0       = we_cnt;
      ae0       = addr_err;
      n = 0;
      while (!o_req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_req_ready) begin
         chk("accept_timeout", o_req_ready, 1);
         req_valid = 1'b0;
         return;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!o_resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb_q.pop_front();
      chk("latency",       lat,           e.lat);
      chk("resp_fault",    o_resp_fault,  e.fault);
      chk("resp_rd",       o_resp_rd,     e.rd);
      chk("resp_tag",      o_resp_tag,    e.tag);
      chk("resp_ready_lo", o_req_ready,   0);
      chk("resp_addr_0",   o_mem_address, 0);
      mem_rd_v = ~rdv;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", o_resp_valid, 1);
         chk("hold_rd",    o_resp_rd,    e.rd);
         chk("hold_tag",   o_resp_tag,   e.tag);
         chk("hold_fault", o_resp_fault, e.fault);
         chk("hold_ready", o_req_ready,  0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("post_valid", o_resp_valid,  0);
      chk("post_ready", o_req_ready,   1);
      chk("post_busy",  o_busy,        0);
      chk("post_addr",  o_mem_address, 0);
      chk("we_pulses",  we_cnt - we0,  e.we_n);
      if (e.we_n == 1) begin
         chk("we_addr", we_addr, addr);
         chk("we_wd",   we_wd,   wd);
         chk("we_vec",  we_vec,  vec);
      end
      chk("addr_stable", addr_err - ae0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n, rv;
      rst        = 1'b0;
      sel        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_vec    = 1'b0;
      req_addr   = '0;
      req_wd     = '0;
      req_tag    = '0;
      resp_ready = 1'b0;
      mem_rd_v   = '0;

      // Reset state of both instances.
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk_zero("rst");
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sel = 1'b0;
      #1;
      chk("rel_ready1", o_req_ready, 1);
      sel = 1'b1;
      #1;
      chk("rel_ready3", o_req_ready, 1);

      // Load, store and fault basics on RD_LAT=1.
      do_req(1'b0, 1'b0, 1'b0, 32'd1500,  '0,           5'd3,  192'hA5, 0);
      do_req(1'b0, 1'b1, 1'b1, 32'd31000, 192'h1234,    5'd4,  '0,      0);
      do_req(1'b0, 1'b1, 1'b0, 32'd5000,  192'hBEEF,    5'd7,  '0,      0);
      do_req(1'b0, 1'b0, 1'b0, 32'd999,   '0,           5'd8,  192'h77, 0);
      do_req(1'b0, 1'b0, 1'b0, 32'd61015, '0,           5'd9,  192'h66, 1);

      // RD_LAT=3 load at the top of RAM with a stalled writeback.
      do_req(1'b1, 1'b0, 1'b1, 32'd61014, '0, 5'd10,
             192'hCAFE_F00D_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF, 4);

      // Region boundaries and extreme addresses.
      do_req(1'b1, 1'b1, 1'b0, 32'd61014,      192'h5A5A, 5'd11, '0,        2);
      do_req(1'b0, 1'b0, 1'b1, 32'd1000,       '0,        5'd12, 192'h1111, 0);
      do_req(1'b1, 1'b0, 1'b0, 32'd30999,     '0,        5'd13, 192'h2222, 1);
      do_req(1'b0, 1'b1, 1'b0, 32'd30999,     192'h3333, 5'd14, '0,        0);
      do_req(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, '0,        5'd31, 192'h4444, 0);
      do_req(1'b1, 1'b1, 1'b1, 32'd0,          192'h5555, 5'd0,  '0,        0);

      // Reset during the WAIT phase of an RD_LAT=3 load.
      @(negedge clk);
      sel       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_vec   = 1'b0;
      req_addr  = 32'd61014;
      req_tag   = 5'd17;
      mem_rd_v  = 192'h9999;
      cur_addr  = 32'd61014;
      n = 0;
      while (!o_req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rw_accept", o_req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rw_busy", o_busy,        1);
      chk("rw_addr", o_mem_address, 32'd61014);
      #2 rst = 1'b1;
      #1;
      chk_zero("rw_async");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rw_hold");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rw_rel_ready", o_req_ready, 1);
      rv = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_resp_valid) rv++;
      end
      chk("rw_no_resp", rv, 0);

`ifdef MEM_STAGE_STATS_EN
      // Statistics after the reset: 3 loads, 2 stores, 1 fault.
      do_req(1'b0, 1'b0, 1'b0, 32'd1000,  '0,     5'd1, 192'h1, 0);
      do_req(1'b0, 1'b1, 1'b0, 32'd31000, 192'h2, 5'd2, '0,     0);
      do_req(1'b0, 1'b0, 1'b1, 32'd2000,  '0,     5'd3, 192'h3, 1);
      do_req(1'b0, 1'b0, 1'b0, 32'd999,   '0,     5'd4, 192'h4, 0);
      do_req(1'b0, 1'b1, 1'b1, 32'd61014, 192'h5, 5'd5, '0,     0);
      do_req(1'b0, 1'b0, 1'b0, 32'd40000, '0,     5'd6, 192'h6, 0);
      chk("stat_loads",   sl1, 3);
      chk("stat_stores",  ss1, 2);
      chk("stat_faults",  sf1, 1);
      chk("stat3_loads",  sl3, 0);
      chk("stat3_stores", ss3, 0);
      chk("stat3_faults", sf3, 0);
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- S, 32, scalar/address width.
- V, 192, vector data width.
- ROM_BASE, 1000, first ROM address.
- RAM_BASE, 31000, first RAM address.
- MEM_END, 61015, first illegal address above RAM.
- RD_LAT, 1, read-data wait cycles, legal 1..4.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, execute-stage request present.
- req_ready, out, 1, request accepted this cycle.
- req_we, in, 1, 1 = store, 0 = load.
- req_vec, in, 1, vector access.
- req_addr, in, S, byte address.
- req_wd, in, V, store data.
- req_tag, in, 5, destination register.
- resp_valid, out, 1, response present.
- resp_ready, in, 1, writeback accepts response.
- resp_rd, out, V, load data.
- resp_tag, out, 5, echoed tag.
- resp_fault, out, 1, illegal access.
- mem_we, out, 1, to memory controller.
- mem_vec, out, 1, to memory controller VecOp.
- mem_address, out, S, to memory controller.
- mem_wd, out, V, to memory controller.
- mem_rd, in, V, from memory controller.
- busy, out, 1, state is not IDLE.

Function
REQ-003 SHALL implement the FSM IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 On req_valid&req_ready, it SHALL capture we, vec, addr, wd and tag, and classify the address.
REQ-005 An address is a fault if addr<ROM_BASE or addr>=MEM_END, or if it is a store with addr<RAM_BASE (ROM write). Comparisons SHALL be unsigned over S bits.
REQ-006 For a fault request it SHALL go IDLE->RESP with resp_fault=1 and resp_rd=0, and SHALL generate no mem_we. Latency is 1 cycle.
REQ-007 For a legal store, ISSUE SHALL last exactly 1 cycle with mem_we=1 and mem_address/mem_wd/mem_vec valid. It then goes to RESP with resp_rd=0. Latency is 2 cycles.
REQ-008 For a legal load, the ISSUE cycle counts as wait cycle 1 and WAIT supplies cycles 2..RD_LAT.
- mem_rd SHALL be captured on the edge ending wait cycle RD_LAT.
- The FSM then goes to RESP.
- Latency from accept to resp_valid is RD_LAT+1 cycles.
REQ-009 mem_address SHALL hold the captured address, stable, throughout ISSUE and WAIT, and be 0 otherwise. mem_we SHALL be 0 outside a store's ISSUE cycle.
REQ-010 In RESP, resp_valid=1 and resp_rd/resp_tag/resp_fault SHALL be held stable until resp_ready. On resp_valid&resp_ready the FSM SHALL return to IDLE.
REQ-011 A new request SHALL NOT be accepted in the RESP cycle that completes the handshake. The earliest next accept is one cycle later.
REQ-012 All mem_* and resp_* outputs SHALL be registered, with no combinational path from req_* or resp_ready to them.
REQ-013 RD_LAT=1 SHALL skip WAIT entirely.

Reset
REQ-014 While rst=1: state=IDLE, and every output SHALL be 0, including req_ready, busy and mem_we.
REQ-015 Reset asserted mid-operation SHALL drop the in-flight request with no response. mem_we SHALL fall asynchronously with rst.
REQ-016 After rst deasserts, req_ready SHALL be 1 on the first clock.

Configuration
REQ-017 With MEM_STAGE_STATS_EN defined, the block SHALL add three 16-bit saturating outputs, stat_loads, stat_stores and stat_faults.
- Each counter increments once per completed response of that kind.
- Each counter resets to 0 and holds at 16'hFFFF.
REQ-018 Without MEM_STAGE_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-019 Package mem_stage_pkg SHALL hold the FSM state enum, the region enum (REG_ROM, REG_RAM, REG_ILLEGAL), the tag width constant 5, and the default map constants.
REQ-020 A combinational sub-module, mem_region_decode, SHALL classify addr and we into region and fault.

Verification
REQ-021 Load from 1500 with RD_LAT=1 and mem_rd=192'hA5:
- resp_valid SHALL rise 2 cycles after accept, with resp_rd=192'hA5 and resp_fault=0.
- mem_we SHALL stay 0.
REQ-022 Store to 31000 with wd=192'h1234: mem_we SHALL be 1 for exactly one cycle with mem_address=31000, and resp_valid SHALL rise 2 cycles after accept.
REQ-023 Store to 5000 (ROM), and load from 999 and from 61015:
- each SHALL give resp_fault=1 after 1 cycle;
- mem_we SHALL never assert.
REQ-024 RD_LAT=3, load from 61014, resp_ready held 0 for 4 cycles:
- resp_valid SHALL rise at accept+4;
- resp data SHALL be stable until resp_ready;
- req_ready SHALL be 0 throughout.
REQ-025 rst pulsed during WAIT of a load: no response SHALL appear, all outputs SHALL be 0 during rst, and req_ready SHALL be 1 on the first clock after release.
REQ-026 With MEM_STAGE_STATS_EN, 3 loads, 2 stores and 1 fault SHALL give stat_loads=3, stat_stores=2 and stat_faults=1.
